block_reader: RTL and testbench

- Read-side controller for the block FIFO.
- Waits for a block buffer to report full (buf_ready low), then walks rd_ptr through entries 0..len-1 and streams each word downstream on a valid/ready handshake.
- After the last word is accepted, pulses buf_clear so the buffer empties and the writer can refill it.
- Sits between the block FIFO and the downstream consumer, such as a packetiser or a UART transmit path.

---
 rtl/blockfifo_pkg.sv | 16 +
 rtl/block_reader.sv | 119 +++++++++++
 tb/tb_block_reader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/blockfifo_pkg.sv
// Shared types and helpers for the block FIFO and its reader.
`timescale 1ns/1ps
package blockfifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CLEAR  = 2'd2
    } reader_state_t;

    // Pointer width used by both ends of the block FIFO.
    function automatic int ADDR_WID(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/block_reader.sv
// Read-side controller: streams a full block buffer out over valid/ready,
// then pulses buf_clear so the writer can refill it.
`timescale 1ns/1ps
module block_reader
    import blockfifo_pkg::*;
#(
    parameter int len     = 8,
    parameter int wid     = 8,
    parameter int addrWid = ADDR_WID(len)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               drain_en,
    input  logic               buf_ready,
    output logic [addrWid-1:0] rd_ptr,
    input  logic [wid-1:0]     rd_data,
    output logic               buf_clear,
    output logic [wid-1:0]     out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               block_done
);
    // state  | meaning
    // IDLE   | waiting for a full buffer (buf_ready low) with drain_en high
    // STREAM | presenting words 0..len-1 on out_data/out_valid
    // CLEAR  | one-cycle buf_clear / block_done pulse, then back to IDLE

    localparam logic [addrWid:0] LAST = (addrWid+1)'(len);

    reader_state_t       state, state_nxt;
    logic [addrWid:0]    count, count_nxt;
    logic [addrWid-1:0]  rd_ptr_nxt;
    logic [wid-1:0]      out_data_nxt;
    logic                out_valid_nxt, buf_clear_nxt, busy_nxt, block_done_nxt;
    logic                accept;

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            buf_clear  <= 1'b0;
            busy       <= 1'b0;
            block_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            rd_ptr     <= rd_ptr_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            buf_clear  <= buf_clear_nxt;
            busy       <= busy_nxt;
            block_done <= block_done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain_en && !buf_ready) state_nxt = STREAM;
            STREAM:  if (accept && count == LAST) state_nxt = CLEAR;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_nxt      = count;
        rd_ptr_nxt     = rd_ptr;
        out_data_nxt   = out_data;
        out_valid_nxt  = out_valid;
        buf_clear_nxt  = 1'b0;
        busy_nxt       = busy;
        block_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (drain_en && !buf_ready) begin
                    out_data_nxt  = rd_data;
                    out_valid_nxt = 1'b1;
                    rd_ptr_nxt    = addrWid'(1);
                    count_nxt     = (addrWid+1)'(1);
                    busy_nxt      = 1'b1;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (count < LAST) begin
                        out_data_nxt = rd_data;
                        count_nxt    = count + 1'b1;
                        // Hold on the last entry rather than stepping past len-1.
                        if (count != LAST - 1'b1)
                            rd_ptr_nxt = rd_ptr + 1'b1;
                    end else begin
                        out_valid_nxt  = 1'b0;
                        buf_clear_nxt  = 1'b1;
                        block_done_nxt = 1'b1;
                    end
                end
            end
            CLEAR: begin
                busy_nxt   = 1'b0;
                rd_ptr_nxt = '0;
                count_nxt  = '0;
            end
            default: begin
                out_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
                rd_ptr_nxt    = '0;
                count_nxt     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_block_reader.sv
// Directed bench for block_reader: a block-buffer model feeds a scoreboard of
// expected words; a negedge monitor pops and compares every accepted word.
`timescale 1ns/1ps
module tb_block_reader;
    logic       clk = 1'b0;
    logic       reset, drain_en, out_ready, fill_req;
    logic       buf_ready, buf_clear, out_valid, busy, block_done;
    logic [1:0] rd_ptr;
    logic [7:0] rd_data, out_data;

    logic       buf_ready5, out_ready5, buf_clear5, out_valid5, busy5, block_done5;
    logic [2:0] rd_ptr5;
    logic [7:0] rd_data5, out_data5;

    logic [7:0] mem [4];
    logic [7:0] mem5 [8];
    logic [7:0] exp_q [$];
    logic [7:0] next_ofs, cur_ofs;
    logic       full;

    int checks = 0, errors = 0;
    int done_cnt = 0, words = 0, acc_in_block = 0, clr5_cnt = 0;
    int base_done, base_words;
    logic       stall = 1'b0;
    logic [7:0] hold_data;
    logic [1:0] hold_ptr;
    logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    block_reader #(.len(4), .wid(8)) u4 (
        .clk(clk), .reset(reset), .drain_en(drain_en), .buf_ready(buf_ready),
        .rd_ptr(rd_ptr), .rd_data(rd_data), .buf_clear(buf_clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .block_done(block_done)
    );

    block_reader #(.len(5), .wid(8)) u5 (
        .clk(clk), .reset(reset), .drain_en(drain_en), .buf_ready(buf_ready5),
        .rd_ptr(rd_ptr5), .rd_data(rd_data5), .buf_clear(buf_clear5),
        .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
        .busy(busy5), .block_done(block_done5)
    );

    // Block buffer model: fills on request, empties on buf_clear or reset.
    assign buf_ready = !full;
    assign rd_data   = 8'(mem[rd_ptr] + cur_ofs);
    assign rd_data5  = mem5[rd_ptr5];

    always @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (buf_clear) begin
            full <= 1'b0;
        end else if (fill_req && !full) begin
            full    <= 1'b1;
            cur_ofs <= next_ofs;
            for (int i = 0; i < 4; i++) exp_q.push_back(8'(mem[i] + next_ofs));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return out_valid;
            1:       return block_done;
            default: return busy;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int n = 0;
        while (!sig(sel) && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(sig(sel)), 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            acc_in_block = 0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_data", 32'(out_data), 32'(hold_data));
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_ptr", 32'(rd_ptr), 32'(hold_ptr));
            end
            chk("done_with_clear", 32'(block_done), 32'(buf_clear));
            if (buf_clear) begin
                chk("clear_after_last", 32'(acc_in_block), 32'd4);
                acc_in_block = 0;
                done_cnt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 32'(out_valid), 32'd0);
                else chk("word_order", 32'(out_data), 32'(exp_q.pop_front()));
                acc_in_block++;
                words++;
            end
            stall     = out_valid && !out_ready;
            hold_data = out_data;
            hold_ptr  = rd_ptr;
        end
        if (!reset && buf_clear5) clr5_cnt++;
    end

    initial begin
        mem  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 8; i++) mem5[i] = 8'(8'hA0 + i);
        cur_ofs = 8'h00; next_ofs = 8'h00;
        reset = 1'b1; drain_en = 1'b1; out_ready = 1'b1; fill_req = 1'b0;
        buf_ready5 = 1'b1; out_ready5 = 1'b1;
        tick(); tick(); tick();
        chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_buf_clear", 32'(buf_clear), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_block_done", 32'(block_done), 32'd0);
        reset = 1'b0;
        tick();

        // 1: full-throughput block
        fill_req = 1'b1;
        wait_for(0, "t1_start");
        fill_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_data", 32'(out_data), 32'(8'h11 * (i + 1)));
            tick();
        end
        chk("t1_clear", 32'(buf_clear), 32'd1);
        chk("t1_done", 32'(block_done), 32'd1);
        chk("t1_valid_low", 32'(out_valid), 32'd0);
        tick();
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_clear_low", 32'(buf_clear), 32'd0);

        // 2: out_ready backpressure pattern
        fill_req = 1'b1;
        wait_for(0, "t2_start");
        fill_req = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            chk("t2_no_early_clear", 32'(buf_clear), 32'd0);
            tick();
        end
        chk("t2_clear", 32'(buf_clear), 32'd1);
        out_ready = 1'b1;
        tick();

        // 3: drain_en low holds the reader idle
        drain_en = 1'b0;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_valid", 32'(out_valid), 32'd0);
            chk("t3_busy", 32'(busy), 32'd0);
            chk("t3_rd_ptr", 32'(rd_ptr), 32'd0);
            tick();
        end
        drain_en = 1'b1;
        tick();
        chk("t3_valid_on", 32'(out_valid), 32'd1);
        chk("t3_first", 32'(out_data), 32'h11);
        wait_for(1, "t3_done");
        tick();

        // 4: reset after the second transfer abandons the block
        fill_req = 1'b1;
        wait_for(0, "t4_start");
        fill_req = 1'b0;
        tick(); tick();
        base_done = done_cnt;
        reset = 1'b1;
        tick();
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("t4_clear", 32'(buf_clear), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("t4_no_clear", 32'(done_cnt), 32'(base_done));
        fill_req = 1'b1;
        wait_for(0, "t4_restart");
        fill_req = 1'b0;
        chk("t4_restart_data", 32'(out_data), 32'h11);
        chk("t4_restart_ptr", 32'(rd_ptr), 32'd1);
        wait_for(1, "t4_done");
        tick();

        // 5: back-to-back blocks with immediate refill
        base_done  = done_cnt;
        base_words = words;
        next_ofs = 8'h00;
        fill_req = 1'b1;
        wait_for(2, "t5_blk1_start");
        next_ofs = 8'h40;
        wait_for(1, "t5_blk1_done");
        tick();
        chk("t5_no_restart_busy", 32'(busy), 32'd0);
        chk("t5_no_restart_valid", 32'(out_valid), 32'd0);
        wait_for(2, "t5_blk2_start");
        fill_req = 1'b0;
        wait_for(1, "t5_blk2_done");
        tick();
        chk("t5_done_pulses", 32'(done_cnt - base_done), 32'd2);
        chk("t5_words", 32'(words - base_words), 32'd8);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: len=5 instance
        buf_ready5 = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t6_valid", 32'(out_valid5), 32'd1);
            chk("t6_data", 32'(out_data5), 32'(8'hA0 + i));
            chk("t6_rd_ptr", 32'(rd_ptr5), (i < 4) ? 32'(i + 1) : 32'd4);
            tick();
        end
        chk("t6_clear", 32'(buf_clear5), 32'd1);
        chk("t6_done", 32'(block_done5), 32'd1);
        chk("t6_valid_low", 32'(out_valid5), 32'd0);
        buf_ready5 = 1'b1;
        tick();
        chk("t6_busy_low", 32'(busy5), 32'd0);
        chk("t6_rd_ptr_zero", 32'(rd_ptr5), 32'd0);
        chk("t6_single_clear", 32'(clr5_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
